ps2_key_event_filter: RTL and testbench

PS2_KEY_EVENT_FILTER -- requirements
Module: ps2_key_event_filter

---
 rtl/ps2_key_pkg.sv | 46 ++++
 rtl/ps2_key_event_filter_if.sv | 45 ++++
 rtl/ps2_event_fifo.sv | 80 ++++++++
 rtl/ps2_key_event_filter.sv | 187 ++++++++++++++++++
 tb/tb_ps2_key_event_filter.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_key_pkg.sv
// ps2_key_pkg
// Shared definitions for the PS/2 key event filter.
// Contents:
//   - scan-code constants (prefix bytes, Enter, protocol/housekeeping bytes)
//   - decoder FSM state encoding
//   - event field widths and the packed {ext, code} event record
//   - helper that recognises protocol bytes that never represent a key
package ps2_key_pkg;

  localparam int CODE_W  = 8;
  localparam int EVENT_W = CODE_W + 1;

  // Prefix bytes of the scan-code set 2 protocol
  localparam logic [CODE_W-1:0] SC_EXT   = 8'hE0;
  localparam logic [CODE_W-1:0] SC_BREAK = 8'hF0;
  localparam logic [CODE_W-1:0] SC_ENTER = 8'h5A;

  // Bytes the keyboard emits that are not key codes when seen outside a prefix
  localparam logic [CODE_W-1:0] SC_NULL   = 8'h00;
  localparam logic [CODE_W-1:0] SC_BAT_OK = 8'hAA;
  localparam logic [CODE_W-1:0] SC_ACK    = 8'hFA;
  localparam logic [CODE_W-1:0] SC_RESEND = 8'hFE;
  localparam logic [CODE_W-1:0] SC_ERROR  = 8'hFF;
  localparam logic [CODE_W-1:0] SC_PAUSE  = 8'hE1;

  // Decoder states: which prefix bytes of the current sequence have been seen
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } dec_state_t;

  // One queued key event
  typedef struct packed {
    logic              ext;
    logic [CODE_W-1:0] code;
  } key_event_t;

  // True for housekeeping bytes that are discarded when no prefix is open
  function automatic logic is_protocol_byte(input logic [CODE_W-1:0] b);
    return (b == SC_NULL)   || (b == SC_BAT_OK) || (b == SC_ACK) ||
           (b == SC_RESEND) || (b == SC_ERROR)  || (b == SC_PAUSE);
  endfunction

endpackage

// File: rtl/ps2_key_event_filter_if.sv
// ps2_key_event_filter_if
// Groups the byte input strobe and the key event handshake of the filter.
// Signals:
//   rx_data / rx_data_en     scan-code byte and its one-cycle valid strobe
//   key_valid / key_ready    head event presented / consumer pops the head
//   key_code / key_ext       make code of the head event and its E0 flag
//   overflow                 sticky "event dropped because FIFO was full"
//   clear_overflow           synchronous clear of overflow
// Modports:
//   slave   the filter itself
//   master  the environment (PS/2 receiver plus event consumer)
interface ps2_key_event_filter_if;

  logic [ps2_key_pkg::CODE_W-1:0] rx_data;
  logic                           rx_data_en;
  logic                           key_valid;
  logic [ps2_key_pkg::CODE_W-1:0] key_code;
  logic                           key_ext;
  logic                           key_ready;
  logic                           overflow;
  logic                           clear_overflow;

  modport slave (
    input  rx_data,
    input  rx_data_en,
    input  key_ready,
    input  clear_overflow,
    output key_valid,
    output key_code,
    output key_ext,
    output overflow
  );

  modport master (
    output rx_data,
    output rx_data_en,
    output key_ready,
    output clear_overflow,
    input  key_valid,
    input  key_code,
    input  key_ext,
    input  overflow
  );

endinterface

// File: rtl/ps2_event_fifo.sv
// ps2_event_fifo
// Synchronous FIFO of DEPTH key events ({ext, code}, 9 bits each).
// Ports:
//   clk, resetn   clock and asynchronous active-low reset
//   push          write push_data (ignored when full unless a pop happens too)
//   push_data     event to store
//   pop           drop the head entry (ignored when empty)
//   head          current head entry, all zeros while empty
//   empty, full   occupancy flags
// DEPTH must be a power of two so the pointers wrap by natural overflow.
module ps2_event_fifo
  import ps2_key_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       push,
  input  key_event_t push_data,
  input  logic       pop,
  output key_event_t head,
  output logic       empty,
  output logic       full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  key_event_t       mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a push
  // when it is being popped.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Head is read straight from the storage flops; masked to zero when empty
  // so the outputs show a clean idle value.
  assign head = empty ? key_event_t'('0) : mem[rd_ptr];

  // Event storage
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers and occupancy
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ps2_key_event_filter.sv
// ps2_key_event_filter
// Turns the raw scan-code byte stream of a PS/2 keyboard into queued make
// events. Prefix bytes (E0 extended, F0 break) are tracked by a small decoder;
// completed makes are pushed into an event FIFO, releases only close the
// sequence. An open prefix is abandoned after TIMEOUT_CYCLES idle cycles.
// Parameters:
//   FIFO_DEPTH      event FIFO entries (power of two, 2..16)
//   TIMEOUT_CYCLES  idle cycles before an open prefix sequence is dropped
// Ports:
//   clk     single clock
//   resetn  asynchronous active-low reset
//   bus     ps2_key_event_filter_if.slave (byte input, event output, overflow)
// Optional feature:
//   PS2_TYPEMATIC_SUPPRESS_EN  when defined, auto-repeat makes of the key that
//   is currently held down are dropped; a matching release re-arms the key.
module ps2_key_event_filter
  import ps2_key_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                    clk,
  input  logic                    resetn,
  ps2_key_event_filter_if.slave   bus
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  dec_state_t    state;
  logic [TW-1:0] idle_cnt;

  logic          make_valid;
  logic          make_ext;
  logic          rel_valid;
  logic          rel_ext;
  key_event_t    make_event;
  key_event_t    rel_event;
  logic          push_req;

  key_event_t    fifo_head;
  logic          fifo_empty;
  logic          fifo_full;
  logic          pop_eff;
  logic          overflow_set;
  logic          overflow_q;

  // Classify the incoming byte against the current prefix state. This has to
  // be combinational so a make reaches the FIFO in the strobe cycle itself.
  always_comb begin
    make_valid = 1'b0;
    make_ext   = 1'b0;
    rel_valid  = 1'b0;
    rel_ext    = 1'b0;
    if (bus.rx_data_en) begin
      case (state)
        ST_IDLE: begin
          make_valid = (bus.rx_data != SC_EXT) && (bus.rx_data != SC_BREAK) &&
                       !is_protocol_byte(bus.rx_data);
        end
        ST_EXT: begin
          make_valid = (bus.rx_data != SC_EXT) && (bus.rx_data != SC_BREAK);
          make_ext   = 1'b1;
        end
        ST_BRK: begin
          rel_valid = 1'b1;
        end
        ST_EXT_BRK: begin
          rel_valid = 1'b1;
          rel_ext   = 1'b1;
        end
        default: begin
          make_valid = 1'b0;
        end
      endcase
    end
  end

  assign make_event = {make_ext, bus.rx_data};
  assign rel_event  = {rel_ext, bus.rx_data};

`ifdef PS2_TYPEMATIC_SUPPRESS_EN
  logic       held_valid;
  key_event_t held_event;
  logic       repeat_hit;
  logic       release_hit;

  assign repeat_hit  = make_valid & held_valid & (held_event == make_event);
  assign release_hit = rel_valid & held_valid & (held_event == rel_event);
  assign push_req    = make_valid & ~repeat_hit;

  // Remember the most recent accepted make so its auto-repeats can be dropped.
  // The key is remembered even if the FIFO had to drop the event.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      held_valid <= 1'b0;
      held_event <= '0;
    end else if (push_req) begin
      held_valid <= 1'b1;
      held_event <= make_event;
    end else if (release_hit) begin
      held_valid <= 1'b0;
    end
  end
`else
  logic unused_release;

  assign push_req       = make_valid;
  assign unused_release = rel_valid ^ rel_event.ext;
`endif

  // Prefix decoder with idle timeout. Every byte strobe restarts the idle
  // count; the count only runs while a prefix is open.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= ST_IDLE;
      idle_cnt <= '0;
    end else if (bus.rx_data_en) begin
      idle_cnt <= '0;
      case (state)
        ST_IDLE: begin
          if (bus.rx_data == SC_EXT) begin
            state <= ST_EXT;
          end else if (bus.rx_data == SC_BREAK) begin
            state <= ST_BRK;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_EXT: begin
          if (bus.rx_data == SC_BREAK) begin
            state <= ST_EXT_BRK;
          end else if (bus.rx_data == SC_EXT) begin
            state <= ST_EXT;
          end else begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end else if (state != ST_IDLE) begin
      if (idle_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
        state    <= ST_IDLE;
        idle_cnt <= '0;
      end else begin
        idle_cnt <= idle_cnt + 1'b1;
      end
    end else begin
      idle_cnt <= '0;
    end
  end

  ps2_event_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .resetn   (resetn),
    .push     (push_req),
    .push_data(make_event),
    .pop      (bus.key_ready),
    .head     (fifo_head),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

  // A push is only lost when the FIFO is full and nothing leaves it this cycle
  assign pop_eff      = bus.key_ready & ~fifo_empty;
  assign overflow_set = push_req & fifo_full & ~pop_eff;

  // Sticky overflow flag; a new drop wins over a simultaneous clear
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      overflow_q <= 1'b0;
    end else if (overflow_set) begin
      overflow_q <= 1'b1;
    end else if (bus.clear_overflow) begin
      overflow_q <= 1'b0;
    end
  end

  assign bus.key_valid = ~fifo_empty;
  assign bus.key_code  = fifo_head.code;
  assign bus.key_ext   = fifo_head.ext;
  assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_ps2_key_event_filter.sv
// tb_ps2_key_event_filter
// Self-checking bench for ps2_key_event_filter. Directed scenarios plus a
// randomized byte stream, all compared against a byte-stream reference model
// that tracks the open prefix bytes and the queued events.
// Build with or without PS2_TYPEMATIC_SUPPRESS_EN; expectations follow it.
module tb_ps2_key_event_filter;
  import ps2_key_pkg::*;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 50000;

  logic clk = 1'b0;
  logic resetn;

  ps2_key_event_filter_if bus();

  ps2_key_event_filter #(
    .FIFO_DEPTH    (DEPTH),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [8:0] mq[$];
  logic       pend_e0;
  logic       pend_f0;
  logic       m_ov;
  logic       held_v;
  logic [8:0] held;
  longint     cyc = 0;
  longint     last_strobe = 0;

  function automatic logic is_ign(input logic [7:0] b);
    return b inside {8'h00, 8'hAA, 8'hFA, 8'hFE, 8'hFF, 8'hE1};
  endfunction

  function automatic logic [8:0] model_head();
    return (mq.size() != 0) ? mq[0] : 9'h000;
  endfunction

  task automatic model_reset();
    mq.delete();
    pend_e0 = 1'b0;
    pend_f0 = 1'b0;
    m_ov    = 1'b0;
    held_v  = 1'b0;
    held    = '0;
  endtask

  // One clock of the reference: prefixes collect until a final byte arrives
  task automatic model_cycle(input logic en, input logic [7:0] d, input logic rdy, input logic clr);
    logic pop, push, is_make, is_rel, ovf;
    logic [8:0] ev;
    pop = rdy && (mq.size() != 0);
    push = 1'b0; is_make = 1'b0; is_rel = 1'b0; ev = '0;
    if (en) begin
      if ((pend_e0 || pend_f0) && (cyc - last_strobe - 1 >= TIMEOUT)) begin
        pend_e0 = 1'b0;
        pend_f0 = 1'b0;
      end
      last_strobe = cyc;
      if (pend_f0) begin
        is_rel = 1'b1; ev = {pend_e0, d}; pend_e0 = 1'b0; pend_f0 = 1'b0;
      end else if (d == 8'hE0) begin
        pend_e0 = 1'b1;
      end else if (d == 8'hF0) begin
        pend_f0 = 1'b1;
      end else if (!pend_e0 && is_ign(d)) begin
        is_make = 1'b0;
      end else begin
        is_make = 1'b1; ev = {pend_e0, d}; pend_e0 = 1'b0;
      end
    end
`ifdef PS2_TYPEMATIC_SUPPRESS_EN
    if (is_make && !(held_v && held == ev)) begin
      push = 1'b1; held = ev; held_v = 1'b1;
    end
    if (is_rel && held_v && held == ev) held_v = 1'b0;
`else
    push = is_make;
`endif
    ovf = push && (mq.size() == DEPTH) && !pop;
    if (ovf) m_ov = 1'b1;
    else if (clr) m_ov = 1'b0;
    if (pop) void'(mq.pop_front());
    if (push && !ovf) mq.push_back(ev);
    cyc++;
  endtask

  // Drive one cycle of inputs from a falling edge, return at the next one
  task automatic apply_stimulus(input logic en, input logic [7:0] d, input logic rdy, input logic clr);
    bus.rx_data_en     = en;
    bus.rx_data        = d;
    bus.key_ready      = rdy;
    bus.clear_overflow = clr;
    @(posedge clk);
    model_cycle(en, d, rdy, clr);
    @(negedge clk);
    bus.rx_data_en     = 1'b0;
    bus.clear_overflow = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    model_reset();
    total++; if (bus.key_valid !== 1'b0) begin bad++; $display("[TB] FAIL rst_valid: got %b expected 0", bus.key_valid); end
    total++; if (bus.key_code !== 8'h00) begin bad++; $display("[TB] FAIL rst_code: got %h expected 00", bus.key_code); end
    total++; if (bus.key_ext !== 1'b0) begin bad++; $display("[TB] FAIL rst_ext: got %b expected 0", bus.key_ext); end
    total++; if (bus.overflow !== 1'b0) begin bad++; $display("[TB] FAIL rst_overflow: got %b expected 0", bus.overflow); end
    resetn = 1'b1;
    @(negedge clk);
    total++; if (bus.key_valid !== 1'b0) begin bad++; $display("[TB] FAIL rst_release_valid: got %b expected 0", bus.key_valid); end
  endtask

  task automatic test_make_break();
    logic [7:0] seq [6];
    int pops;
    seq = '{8'h00, 8'hF0, 8'h00, 8'h1C, 8'h00, 8'h00};
    pops = 0;
    apply_stimulus(1'b1, 8'h1C, 1'b1, 1'b0);
    total++; if (bus.key_valid !== 1'b1) begin bad++; $display("[TB] FAIL mb_valid: got %b expected 1", bus.key_valid); end
    total++; if (bus.key_code !== 8'h1C) begin bad++; $display("[TB] FAIL mb_code: got %h expected 1c", bus.key_code); end
    total++; if (bus.key_ext !== 1'b0) begin bad++; $display("[TB] FAIL mb_ext: got %b expected 0", bus.key_ext); end
    if (bus.key_valid && bus.key_ready) pops++;
    for (int i = 0; i < 6; i++) begin
      apply_stimulus(i % 2 == 1, seq[i], 1'b1, 1'b0);
      if (bus.key_valid && bus.key_ready) pops++;
    end
    total++; if (pops !== 1) begin bad++; $display("[TB] FAIL mb_event_count: got %0d expected 1", pops); end
    total++; if (bus.key_valid !== 1'b0) begin bad++; $display("[TB] FAIL mb_empty_after: got %b expected 0", bus.key_valid); end
  endtask

  task automatic test_extended();
    logic [7:0] seq [5];
    seq = '{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75};
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(1'b1, seq[i], 1'b0, 1'b0);
      if (i == 1) begin
        total++; if (bus.key_valid !== 1'b1 || bus.key_code !== 8'h75 || bus.key_ext !== 1'b1)
          begin bad++; $display("[TB] FAIL ext_make: got v=%b code=%h ext=%b expected v=1 code=75 ext=1", bus.key_valid, bus.key_code, bus.key_ext); end
      end
      apply_stimulus(1'b0, 8'h00, 1'b0, 1'b0);
    end
    total++; if (bus.key_code !== 8'h75 || bus.key_ext !== 1'b1)
      begin bad++; $display("[TB] FAIL ext_hold: got code=%h ext=%b expected code=75 ext=1", bus.key_code, bus.key_ext); end
    apply_stimulus(1'b0, 8'h00, 1'b1, 1'b0);
    total++; if (bus.key_valid !== 1'b0) begin bad++; $display("[TB] FAIL ext_single_event: got valid=%b expected 0", bus.key_valid); end
    apply_stimulus(1'b1, 8'h1C, 1'b0, 1'b0);
    total++; if (bus.key_valid !== 1'b1 || bus.key_code !== 8'h1C || bus.key_ext !== 1'b0)
      begin bad++; $display("[TB] FAIL ext_back_to_idle: got v=%b code=%h ext=%b expected v=1 code=1c ext=0", bus.key_valid, bus.key_code, bus.key_ext); end
    apply_stimulus(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic test_overflow();
    logic [7:0] seq [5];
    logic [7:0] drain [4];
    seq   = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E};
    drain = '{8'h1E, 8'h26, 8'h25, 8'h3D};
    for (int i = 0; i < 5; i++) apply_stimulus(1'b1, seq[i], 1'b0, 1'b0);
    total++; if (bus.overflow !== 1'b1) begin bad++; $display("[TB] FAIL ovf_set: got %b expected 1", bus.overflow); end
    total++; if (bus.key_code !== 8'h16) begin bad++; $display("[TB] FAIL ovf_head: got %h expected 16", bus.key_code); end
    apply_stimulus(1'b1, 8'h36, 1'b0, 1'b1);
    total++; if (bus.overflow !== 1'b1) begin bad++; $display("[TB] FAIL ovf_clear_vs_new: got %b expected 1", bus.overflow); end
    apply_stimulus(1'b0, 8'h00, 1'b0, 1'b1);
    total++; if (bus.overflow !== 1'b0) begin bad++; $display("[TB] FAIL ovf_clear: got %b expected 0", bus.overflow); end
    apply_stimulus(1'b1, 8'h3D, 1'b1, 1'b0);
    total++; if (bus.overflow !== 1'b0) begin bad++; $display("[TB] FAIL ovf_full_push_pop: got %b expected 0", bus.overflow); end
    for (int i = 0; i < 4; i++) begin
      total++; if (bus.key_valid !== 1'b1 || bus.key_code !== drain[i])
        begin bad++; $display("[TB] FAIL ovf_order[%0d]: got v=%b code=%h expected v=1 code=%h", i, bus.key_valid, bus.key_code, drain[i]); end
      apply_stimulus(1'b0, 8'h00, 1'b1, 1'b0);
    end
    total++; if (bus.key_valid !== 1'b0) begin bad++; $display("[TB] FAIL ovf_drained: got %b expected 0", bus.key_valid); end
  endtask

  task automatic test_push_pop_empty();
    apply_stimulus(1'b1, 8'h4D, 1'b1, 1'b0);
    total++; if (bus.key_valid !== 1'b1 || bus.key_code !== 8'h4D)
      begin bad++; $display("[TB] FAIL ppe_stored: got v=%b code=%h expected v=1 code=4d", bus.key_valid, bus.key_code); end
    apply_stimulus(1'b0, 8'h00, 1'b1, 1'b0);
    total++; if (bus.key_valid !== 1'b0) begin bad++; $display("[TB] FAIL ppe_popped: got %b expected 0", bus.key_valid); end
  endtask

  task automatic test_typematic();
    logic [7:0] seq [6];
    int n, exp_n;
    seq = '{8'h1C, 8'h1C, 8'h1C, 8'hF0, 8'h1C, 8'h1C};
`ifdef PS2_TYPEMATIC_SUPPRESS_EN
    exp_n = 2;
`else
    exp_n = 4;
`endif
    for (int i = 0; i < 6; i++) begin
      apply_stimulus(1'b1, seq[i], 1'b0, 1'b0);
      apply_stimulus(1'b0, 8'h00, 1'b0, 1'b0);
    end
    total++; if (bus.overflow !== 1'b0) begin bad++; $display("[TB] FAIL typ_overflow: got %b expected 0", bus.overflow); end
    n = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.key_valid) begin
        n++;
        total++; if (bus.key_code !== 8'h1C) begin bad++; $display("[TB] FAIL typ_code: got %h expected 1c", bus.key_code); end
      end
      apply_stimulus(1'b0, 8'h00, 1'b1, 1'b0);
    end
    total++; if (n !== exp_n) begin bad++; $display("[TB] FAIL typ_count: got %0d expected %0d", n, exp_n); end
  endtask

  task automatic test_timeout();
    int n;
    n = 0;
    apply_stimulus(1'b1, 8'hF0, 1'b1, 1'b0);
    repeat (20) apply_stimulus(1'b0, 8'h00, 1'b1, 1'b0);
    apply_stimulus(1'b1, 8'h5A, 1'b1, 1'b0);
    if (bus.key_valid) n++;
    repeat (3) begin
      apply_stimulus(1'b0, 8'h00, 1'b1, 1'b0);
      if (bus.key_valid) n++;
    end
    total++; if (n !== 0) begin bad++; $display("[TB] FAIL to_short_release: got %0d events expected 0", n); end
    apply_stimulus(1'b1, 8'hF0, 1'b1, 1'b0);
    repeat (TIMEOUT) apply_stimulus(1'b0, 8'h00, 1'b1, 1'b0);
    apply_stimulus(1'b1, 8'h5A, 1'b1, 1'b0);
    total++; if (bus.key_valid !== 1'b1 || bus.key_code !== 8'h5A || bus.key_ext !== 1'b0)
      begin bad++; $display("[TB] FAIL to_expired: got v=%b code=%h ext=%b expected v=1 code=5a ext=0", bus.key_valid, bus.key_code, bus.key_ext); end
    apply_stimulus(1'b0, 8'h00, 1'b1, 1'b0);
    total++; if (bus.key_valid !== 1'b0) begin bad++; $display("[TB] FAIL to_popped: got %b expected 0", bus.key_valid); end
  endtask

  task automatic test_reset_mid();
    apply_stimulus(1'b1, 8'h2B, 1'b0, 1'b0);
    apply_stimulus(1'b1, 8'hE0, 1'b0, 1'b0);
    #2 resetn = 1'b0;
    model_reset();
    #1;
    total++; if (bus.key_valid !== 1'b0 || bus.key_code !== 8'h00 || bus.overflow !== 1'b0)
      begin bad++; $display("[TB] FAIL rm_async: got v=%b code=%h ovf=%b expected v=0 code=00 ovf=0", bus.key_valid, bus.key_code, bus.overflow); end
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    apply_stimulus(1'b1, 8'h75, 1'b0, 1'b0);
    total++; if (bus.key_valid !== 1'b1 || bus.key_code !== 8'h75 || bus.key_ext !== 1'b0)
      begin bad++; $display("[TB] FAIL rm_fresh_decode: got v=%b code=%h ext=%b expected v=1 code=75 ext=0", bus.key_valid, bus.key_code, bus.key_ext); end
    apply_stimulus(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    logic [7:0] pool [15];
    logic en, rdy, clr;
    logic [7:0] d;
    logic [8:0] exp_h;
    pool = '{8'hE0, 8'hF0, 8'h00, 8'hAA, 8'h1C, 8'h1D, 8'h75, 8'h5A,
             8'h2B, 8'h6B, 8'hE1, 8'hFE, 8'hF0, 8'hE0, 8'h1C};
    for (int i = 0; i < 600; i++) begin
      en  = ($urandom_range(0, 2) == 0);
      d   = pool[$urandom_range(0, 14)];
      rdy = (i < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 15) == 0);
      apply_stimulus(en, d, rdy, clr);
      exp_h = model_head();
      total++; if (bus.key_valid !== (mq.size() != 0))
        begin bad++; $display("[TB] FAIL rnd_valid @%0d: got %b expected %b", i, bus.key_valid, (mq.size() != 0)); end
      total++; if (bus.key_code !== exp_h[7:0])
        begin bad++; $display("[TB] FAIL rnd_code @%0d: got %h expected %h", i, bus.key_code, exp_h[7:0]); end
      total++; if (bus.key_ext !== exp_h[8])
        begin bad++; $display("[TB] FAIL rnd_ext @%0d: got %b expected %b", i, bus.key_ext, exp_h[8]); end
      total++; if (bus.overflow !== m_ov)
        begin bad++; $display("[TB] FAIL rnd_overflow @%0d: got %b expected %b", i, bus.overflow, m_ov); end
    end
  endtask

  initial begin
    resetn             = 1'b0;
    bus.rx_data        = 8'h00;
    bus.rx_data_en     = 1'b0;
    bus.key_ready      = 1'b0;
    bus.clear_overflow = 1'b0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_make_break();
    test_extended();
    test_overflow();
    test_push_pop_empty();
    test_typematic();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
